cipher_block_uart_tx: RTL and testbench

- Transmitter counterpart to the plaintext UART receive path.
- Accepts one 128-bit AES cipher-text block via a valid/ready handshake and latches it.
- Serializes the block as 16 bytes of UART 8N1 on a single TX line.
- Sits between the cipher-text capture register and the board UART TX pin; replaces ad-hoc TX handling in the top-level controller.

---
 rtl/aes_uart_pkg.sv | 27 ++
 rtl/cipher_block_uart_tx_if.sv | 29 ++
 rtl/uart_tx_byte.sv | 127 ++++++++++++
 rtl/cipher_block_uart_tx.sv | 93 +++++++++
 tb/tb_cipher_block_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_uart_pkg.sv
// -----------------------------------------------------------------------------
// aes_uart_pkg
// Shared definitions for the AES cipher-text UART transmit path.
//   N_DATA_BITS          data bits per UART frame
//   N_BYTES              bytes per cipher-text block
//   BLOCK_BITS           width of one cipher-text block
//   CLKS_PER_BIT_DEFAULT clk cycles per UART bit (100 MHz / 115200)
//   tx_state_t           framing states of the byte transmitter
//   block_t              one cipher-text block
// -----------------------------------------------------------------------------
package aes_uart_pkg;

  localparam int N_DATA_BITS          = 8;
  localparam int N_BYTES              = 16;
  localparam int BLOCK_BITS           = N_BYTES * N_DATA_BITS;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  typedef logic [BLOCK_BITS-1:0] block_t;

endpackage

// File: rtl/cipher_block_uart_tx_if.sv
// -----------------------------------------------------------------------------
// cipher_block_uart_tx_if
// Valid/ready handshake carrying one cipher-text block to the transmitter.
//   i_block        cipher-text block, byte k = i_block[8k+7:8k]
//   i_block_valid  producer has a block
//   o_block_ready  transmitter can take a block (transfer on valid && ready)
// Modports: master = block producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface cipher_block_uart_tx_if #(
  parameter int BLOCK_W = aes_uart_pkg::BLOCK_BITS
) ();

  logic [BLOCK_W-1:0] i_block;
  logic               i_block_valid;
  logic               o_block_ready;

  modport master (
    output i_block,
    output i_block_valid,
    input  o_block_ready
  );

  modport slave (
    input  i_block,
    input  i_block_valid,
    output o_block_ready
  );

endinterface

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Frames one byte as UART 8N1 (start, data LSB first, stop) and counts baud.
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   byte_valid  load byte_data; sampled in IDLE and in the final stop cycle,
//               so a following byte can be chained with no idle gap
//   byte_data   byte to send
//   byte_last   marks the final byte of a block; travels with the byte
//   tx          registered serial line, idles high
//   byte_done   one-cycle pulse during the final cycle of the stop bit
//   block_done  byte_done qualified by the byte_last flag of that byte
// -----------------------------------------------------------------------------
module uart_tx_byte
  import aes_uart_pkg::tx_state_t, aes_uart_pkg::IDLE, aes_uart_pkg::START,
         aes_uart_pkg::DATA, aes_uart_pkg::STOP;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int N_DATA_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   byte_valid,
  input  logic [N_DATA_BITS-1:0] byte_data,
  input  logic                   byte_last,
  output logic                   tx,
  output logic                   byte_done,
  output logic                   block_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (N_DATA_BITS > 1) ? $clog2(N_DATA_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // The done pulses are registered, so they are set one cycle ahead to land
  // exactly on the last stop-bit cycle.
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_DATA_BITS - 1);

  tx_state_t              state;
  logic [CNT_W-1:0]       baud_cnt;
  logic [BIT_W-1:0]       bit_idx;
  logic [N_DATA_BITS-1:0] data_q;
  logic                   last_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      // NOTE: the data holding register is reset as well; it is small, and a
      // known value keeps an aborted frame from leaking into the next one.
      data_q     <= '0;
      last_q     <= 1'b0;
      tx         <= 1'b1;
      byte_done  <= 1'b0;
      block_done <= 1'b0;
    end else begin
      byte_done  <= 1'b0;
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_valid) begin
            data_q   <= byte_data;
            last_q   <= byte_last;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= data_q[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // The current bit always sits in data_q[0]; shift to expose the next.
              bit_idx <= bit_idx + BIT_W'(1);
              data_q  <= data_q >> 1;
              tx      <= data_q[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_cnt == CNT_DONE) begin
            byte_done  <= 1'b1;
            block_done <= last_q;
          end
          if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
            if (byte_valid) begin
              data_q <= byte_data;
              last_q <= byte_last;
              tx     <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cipher_block_uart_tx.sv
// -----------------------------------------------------------------------------
// cipher_block_uart_tx
// Accepts one cipher-text block over a valid/ready handshake, latches it and
// sends it as N_BYTES back-to-back UART 8N1 frames, byte 0 first.
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   blk           block handshake (slave side): i_block, i_block_valid,
//                 o_block_ready (registered, high only while idle)
//   o_uart_tx     serial line, idles high, returns high at once on reset
//   o_busy        high from acceptance until the final stop bit ends
//   o_byte_done   one-cycle pulse at the end of each byte's stop bit
//   o_block_done  one-cycle pulse coincident with the final o_byte_done
// -----------------------------------------------------------------------------
module cipher_block_uart_tx
  import aes_uart_pkg::CLKS_PER_BIT_DEFAULT;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int N_DATA_BITS  = aes_uart_pkg::N_DATA_BITS,
  parameter int N_BYTES      = aes_uart_pkg::N_BYTES
) (
  input  logic                   clk,
  input  logic                   reset,
  cipher_block_uart_tx_if.slave  blk,
  output logic                   o_uart_tx,
  output logic                   o_busy,
  output logic                   o_byte_done,
  output logic                   o_block_done
);

  localparam int BLOCK_W = N_BYTES * N_DATA_BITS;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [BLOCK_W-1:0]     shift_buf;
  logic [IDX_W-1:0]       byte_idx;
  logic                   accept;
  logic                   chain;
  logic                   byte_valid;
  logic                   byte_last;
  logic [N_DATA_BITS-1:0] byte_data;

  // A new block's first byte goes straight from i_block into the framer so
  // the start bit appears the cycle after the accepting edge.
  assign accept = blk.o_block_ready && blk.i_block_valid;

  // The framer's byte_done marks its final stop cycle, which is exactly when
  // it can take the next byte without an idle gap.
  assign chain = o_busy && o_byte_done && !o_block_done;

  assign byte_valid = accept || chain;
  assign byte_data  = accept ? blk.i_block[N_DATA_BITS-1:0]
                             : shift_buf[2*N_DATA_BITS-1:N_DATA_BITS];
  assign byte_last  = accept ? (N_BYTES == 1)
                             : (byte_idx == IDX_W'(N_BYTES - 2));

  // o_busy doubles as the block-level state: low = IDLE, high = sending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk.o_block_ready <= 1'b0;
      o_busy            <= 1'b0;
      shift_buf         <= '0;
      byte_idx          <= '0;
    end else if (accept) begin
      blk.o_block_ready <= 1'b0;
      o_busy            <= 1'b1;
      shift_buf         <= blk.i_block;
      byte_idx          <= '0;
    end else if (chain) begin
      // Keep the byte on the line in the low slot; the next one sits above it.
      shift_buf <= shift_buf >> N_DATA_BITS;
      byte_idx  <= byte_idx + IDX_W'(1);
    end else if (o_busy && o_block_done) begin
      o_busy            <= 1'b0;
      blk.o_block_ready <= 1'b1;
    end else if (!o_busy) begin
      blk.o_block_ready <= 1'b1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .N_DATA_BITS  (N_DATA_BITS)
  ) u_tx_byte (
    .clk        (clk),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .tx         (o_uart_tx),
    .byte_done  (o_byte_done),
    .block_done (o_block_done)
  );

endmodule

// File: tb/tb_cipher_block_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_cipher_block_uart_tx
// Bench for cipher_block_uart_tx: one instance at 4 clk/bit, one at the
// minimum of 2 clk/bit. A frame decoder per instance pops expected bytes from
// a queue filled when each block is handed over.
// -----------------------------------------------------------------------------
module tb_cipher_block_uart_tx;
  import aes_uart_pkg::*;

  localparam int C1 = 4;
  localparam int C2 = 2;

  typedef struct {
    block_t blk;
    int     exp_cycles;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cipher_block_uart_tx_if bif1 ();
  cipher_block_uart_tx_if bif2 ();

  logic tx1, busy1, bd1, kd1;
  logic tx2, busy2, bd2, kd2;

  cipher_block_uart_tx #(.CLKS_PER_BIT(C1)) dut1 (
    .clk          (clk),
    .reset        (rst_n),
    .blk          (bif1),
    .o_uart_tx    (tx1),
    .o_busy       (busy1),
    .o_byte_done  (bd1),
    .o_block_done (kd1)
  );

  cipher_block_uart_tx #(.CLKS_PER_BIT(C2)) dut2 (
    .clk          (clk),
    .reset        (rst_n),
    .blk          (bif2),
    .o_uart_tx    (tx2),
    .o_busy       (busy2),
    .o_byte_done  (bd2),
    .o_block_done (kd2)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  bit mon_en1 = 1'b0;
  bit mon_en2 = 1'b0;
  int byte_pulses1 = 0;
  int block_pulses1 = 0;
  int byte_pulses2 = 0;

  always @(negedge clk) begin
    if (bd1 === 1'b1) byte_pulses1 <= byte_pulses1 + 1;
    if (kd1 === 1'b1) block_pulses1 <= block_pulses1 + 1;
    if (bd2 === 1'b1) byte_pulses2 <= byte_pulses2 + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 0) ? tx1 : tx2;
  endfunction

  function automatic logic bdone(input int sel);
    return (sel == 0) ? bd1 : bd2;
  endfunction

  function automatic logic kdone(input int sel);
    return (sel == 0) ? kd1 : kd2;
  endfunction

  function automatic logic rdy(input int sel);
    return (sel == 0) ? bif1.o_block_ready : bif2.o_block_ready;
  endfunction

  // Reference UART receiver: samples each bit at its centre and checks the
  // byte_done pulse on the final stop-bit cycle.
  task automatic monitor(input int sel);
    int cpb;
    logic [7:0] data;
    logic start_b, stop_b;
    cpb = (sel == 0) ? C1 : C2;
    forever begin
      @(negedge clk);
      if (((sel == 0) ? mon_en1 : mon_en2) && line(sel) === 1'b0) begin
        repeat (cpb / 2) @(negedge clk);
        start_b = line(sel);
        for (int j = 0; j < 8; j++) begin
          repeat (cpb) @(negedge clk);
          data[j] = line(sel);
        end
        repeat (cpb) @(negedge clk);
        stop_b = line(sel);
        repeat (cpb - 1 - cpb / 2) @(negedge clk);
        check($sformatf("start_bit%0d", sel), start_b, 1'b0);
        check($sformatf("stop_bit%0d", sel), stop_b, 1'b1);
        check($sformatf("byte_done_at_stop_end%0d", sel), bdone(sel), 1'b1);
        if (((sel == 0) ? q1.size() : q2.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame%0d: actual byte %0h required none", sel, data);
        end else if (sel == 0) begin
          check("rx_byte0", data, q1.pop_front());
        end else begin
          check("rx_byte1", data, q2.pop_front());
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Called just after a negedge; returns at the negedge of the first
  // start-bit cycle. i_block_valid is left high.
  task automatic send(input int sel, input block_t b, input bit push);
    bit ok;
    ok = 1'b0;
    if (sel == 0) begin
      bif1.i_block = b;
      bif1.i_block_valid = 1'b1;
    end else begin
      bif2.i_block = b;
      bif2.i_block_valid = 1'b1;
    end
    for (int n = 0; n < 50 && !ok; n++) begin
      if (rdy(sel) === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout%0d: actual not accepted required accepted", sel);
    end
    if (push) begin
      for (int k = 0; k < 16; k++) begin
        if (sel == 0) q1.push_back(b[8*k +: 8]);
        else q2.push_back(b[8*k +: 8]);
      end
    end
  endtask

  // Starts on first start-bit cycle (n=1); returns on the block_done cycle.
  task automatic wait_done(input int sel, input int budget, output int n, output int ready_hi);
    n = 1;
    ready_hi = 0;
    while (kdone(sel) !== 1'b1 && n < budget) begin
      if (rdy(sel) !== 1'b0) ready_hi++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[3];
    block_t a, b, r, v, w;
    int n, rh, bp0, kp0, lows;

    vecs[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 640};
    vecs[1] = '{128'h00FF00FF00FF00FF00FF00FF00FF00FF, 640};
    vecs[2] = '{128'h5AC39E017F80DEADBEEF12345678A55A, 640};

    rst_n = 1'b0;
    bif1.i_block = '0;
    bif1.i_block_valid = 1'b0;
    bif2.i_block = '0;
    bif2.i_block_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_tx", tx1, 1'b1);
    check("reset_ready", bif1.o_block_ready, 1'b0);
    check("reset_busy", busy1, 1'b0);
    check("reset_byte_done", bd1, 1'b0);
    check("reset_block_done", kd1, 1'b0);

    rst_n = 1'b1;
    #1;
    check("ready_before_first_edge", bif1.o_block_ready, 1'b0);
    @(negedge clk);
    check("ready_after_reset", bif1.o_block_ready, 1'b1);
    check("busy_after_reset", busy1, 1'b0);
    mon_en1 = 1'b1;
    mon_en2 = 1'b1;

    // Table-driven blocks; i_block is scrambled right after acceptance.
    for (int i = 0; i < 3; i++) begin
      send(0, vecs[i].blk, 1'b1);
      check("start_latency", tx1, 1'b0);
      check("busy_after_accept", busy1, 1'b1);
      check("ready_after_accept", bif1.o_block_ready, 1'b0);
      bif1.i_block = ~vecs[i].blk;
      bif1.i_block_valid = 1'b0;
      bp0 = byte_pulses1;
      wait_done(0, 2000, n, rh);
      check("block_cycles", n, vecs[i].exp_cycles);
      check("byte_done_with_block_done", bd1, 1'b1);
      check("ready_low_while_busy", rh, 0);
      @(negedge clk);
      check("ready_after_block", bif1.o_block_ready, 1'b1);
      check("busy_after_block", busy1, 1'b0);
      check("tx_idle_after_block", tx1, 1'b1);
      check("byte_pulses", byte_pulses1 - bp0, 16);
      check("queue_drained", q1.size(), 0);
    end

    // Valid held high: A is sent untouched while i_block switches to B,
    // then B is taken in the first idle cycle.
    a = 128'h00112233445566778899AABBCCDDEEFF;
    b = 128'hFFEEDDCCBBAA99887766554433221100;
    send(0, a, 1'b1);
    bif1.i_block = b;
    wait_done(0, 2000, n, rh);
    check("b2b_block_cycles_a", n, 640);
    check("b2b_ready_low_while_busy", rh, 0);
    @(negedge clk);
    check("b2b_idle_ready", bif1.o_block_ready, 1'b1);
    check("b2b_idle_gap_tx", tx1, 1'b1);
    for (int k = 0; k < 16; k++) q1.push_back(b[8*k +: 8]);
    @(negedge clk);
    check("b2b_start_b", tx1, 1'b0);
    check("b2b_ready_b", bif1.o_block_ready, 1'b0);
    bif1.i_block_valid = 1'b0;
    wait_done(0, 2000, n, rh);
    check("b2b_block_cycles_b", n, 640);
    @(negedge clk);
    check("b2b_queue_drained", q1.size(), 0);

    // Reset during byte 5, bit 3 (byte 5 = 0x00, so the line is low there).
    mon_en1 = 1'b0;
    r = {16{8'hA5}};
    r[47:40] = 8'h00;
    r[39:32] = 8'hFF;
    kp0 = block_pulses1;
    send(0, r, 1'b0);
    bif1.i_block_valid = 1'b0;
    repeat (217) @(negedge clk);
    check("byte5_bit3_low", tx1, 1'b0);
    check("busy_mid_block", busy1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx1, 1'b1);
    check("async_reset_busy", busy1, 1'b0);
    check("async_reset_ready", bif1.o_block_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) lows++;
    end
    check("no_block_done_after_abort", block_pulses1 - kp0, 0);
    check("line_idle_after_abort", lows, 0);
    check("ready_after_abort", bif1.o_block_ready, 1'b1);
    mon_en1 = 1'b1;
    v = 128'h0102030405060708090A0B0C0D0E0F5A;
    send(0, v, 1'b1);
    bif1.i_block_valid = 1'b0;
    wait_done(0, 2000, n, rh);
    check("post_abort_block_cycles", n, 640);
    @(negedge clk);
    check("post_abort_queue_drained", q1.size(), 0);

    // Minimum bit period on the second instance.
    w = 128'h80014002200410080810042002400180;
    bp0 = byte_pulses2;
    send(1, w, 1'b1);
    check("c2_start_latency", tx2, 1'b0);
    bif2.i_block_valid = 1'b0;
    wait_done(1, 1000, n, rh);
    check("c2_block_cycles", n, 320);
    @(negedge clk);
    check("c2_byte_pulses", byte_pulses2 - bp0, 16);
    check("c2_ready_after_block", bif2.o_block_ready, 1'b1);
    check("c2_queue_drained", q2.size(), 0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
